// File: rtl/uart_tx_fifo_if.sv
// Byte push channel into the serial transmitter: the producer offers DATA with
// VALID and the transmitter accepts it on any rising edge where READY is high.
interface uart_tx_fifo_if;
  logic [7:0] DATA;
  logic       VALID;
  logic       READY;

  // Producer side drives the byte and its qualifier.
  modport master (
    output DATA,
    output VALID,
    input  READY
  );

  // Transmitter side consumes the byte and reports room in its queue.
  modport slave (
    input  DATA,
    input  VALID,
    output READY
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 asynchronous serial transmitter with a small byte queue in front of it.
// Bytes pushed over the valid/ready channel are queued, then shifted onto TX
// LSB first, framed by one low start bit and one high stop bit. Back-to-back
// frames run with no idle gap while the queue has data.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           CLKIN,
  input  logic           RESET,
  uart_tx_fifo_if.slave  push,
  output logic           TX,
  output logic           BUSY
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      BAUD_LAST  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  state_t      state;
  logic [7:0]  shift_reg;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;

  logic push_fire;
  logic pop_fire;
  logic fifo_nonempty;
  logic baud_wrap;

  // Room is judged only from the registered occupancy, so VALID/DATA never
  // reach READY combinationally; READY is forced low while reset is held.
  assign push.READY    = (count != FULL_COUNT) && !RESET;
  assign push_fire     = push.VALID && push.READY;
  assign fifo_nonempty = (count != '0);
  assign baud_wrap     = (baud_cnt == BAUD_LAST);

  // A byte leaves the queue either when the line is idle or exactly at the end
  // of a stop bit, which is what gives gapless back-to-back frames.
  assign pop_fire = fifo_nonempty &&
                    ((state == S_IDLE) || ((state == S_STOP) && baud_wrap));

  assign BUSY = (state != S_IDLE) || fifo_nonempty;

  // Queue storage; stale contents are harmless because the count gates reads.
  always_ff @(posedge CLKIN) begin
    if (push_fire) begin
      mem[wr_ptr] <= push.DATA;
    end
  end

  // Queue pointers and occupancy; simultaneous push and pop cancel out.
  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer: loads a byte, then walks start, eight data and stop bits,
  // each held for one full baud period, with TX driven from a register.
  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      TX        <= 1'b1;
      shift_reg <= '0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          TX <= 1'b1;
          if (pop_fire) begin
            shift_reg <= mem[rd_ptr];
            baud_cnt  <= '0;
            bit_idx   <= '0;
            TX        <= 1'b0;
            state     <= S_START;
          end
        end

        S_START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            TX       <= shift_reg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              TX    <= 1'b1;
              state <= S_STOP;
            end else begin
              shift_reg <= shift_reg >> 1;
              bit_idx   <= bit_idx + 1'b1;
              TX        <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (pop_fire) begin
              shift_reg <= mem[rd_ptr];
              bit_idx   <= '0;
              TX        <= 1'b0;
              state     <= S_START;
            end else begin
              TX    <= 1'b1;
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          TX    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
